// File: rtl/branch_pc_unit.sv
// Branch resolution and fetch-PC stage: owns the fetch PC, redirects on taken branches, and drives a multi-cycle flush.
// Optional macro BRANCH_STATS_EN adds branch_count / taken_count statistics outputs.
module branch_pc_unit #(
    parameter logic [31:0]  RESET_PC     = 32'h0000_0000,
    parameter int unsigned  FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic        outcome,
`ifdef BRANCH_STATS_EN
    output logic [31:0] branch_count,
    output logic [31:0] taken_count,
`endif
    output logic [31:0] pc,
    output logic        redirect,
    output logic        flush,
    output logic        busy,
    output logic        misalign
);

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned PC_W    = 32;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PC_W-1:0]   r_pc;
    logic              r_redirect;
    logic              r_flush;
    logic              r_busy;
    logic              r_misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0]       r_branch_count;
    logic [31:0]       r_taken_count;
`endif

    logic [PC_W-1:0]   w_target;
    logic [PC_W-1:0]   w_pc_inc;
    logic              w_taken;
    logic              w_aligned;

    // outcome is gated by br_valid so an unknown comparator result cannot leak through
    assign w_target  = br_pc + br_imm;
    assign w_pc_inc  = r_pc + PC_W'(4);
    assign w_taken   = br_valid & outcome;
    assign w_aligned = (w_target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
            r_busy     <= 1'b0;
            r_misalign <= 1'b0;
`ifdef BRANCH_STATS_EN
            r_branch_count <= '0;
            r_taken_count  <= '0;
`endif
        end else begin
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!stall) begin
                        if (w_taken && w_aligned) begin
                            r_pc       <= w_target;
                            r_redirect <= 1'b1;
                            r_flush    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_cnt      <= CNT_LOAD;
                            r_state    <= S_FLUSH;
                        end else begin
                            r_pc       <= w_pc_inc;
                            r_misalign <= w_taken;
                        end
`ifdef BRANCH_STATS_EN
                        if (br_valid) begin
                            r_branch_count <= r_branch_count + 32'd1;
                        end
                        if (w_taken && w_aligned) begin
                            r_taken_count <= r_taken_count + 32'd1;
                        end
`endif
                    end
                end
                S_FLUSH: begin
                    // stall freezes pc, counter and flush together
                    if (!stall) begin
                        r_pc <= w_pc_inc;
                        if (r_cnt == '0) begin
                            r_flush <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign redirect = r_redirect;
    assign flush    = r_flush;
    assign busy     = r_busy;
    assign misalign = r_misalign;
`ifdef BRANCH_STATS_EN
    assign branch_count = r_branch_count;
    assign taken_count  = r_taken_count;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: driver pushes model predictions, monitor pops and compares each cycle.
module tb_branch_pc_unit;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int unsigned FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset, stall, br_valid, outcome;
    logic [31:0] br_pc, br_imm;
    logic [31:0] pc;
    logic        redirect, flush, busy, misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count, taken_count;
`endif

    branch_pc_unit #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .br_pc(br_pc), .br_imm(br_imm), .outcome(outcome),
`ifdef BRANCH_STATS_EN
        .branch_count(branch_count), .taken_count(taken_count),
`endif
        .pc(pc), .redirect(redirect), .flush(flush), .busy(busy), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        redirect;
        logic        flush;
        logic        busy;
        logic        misalign;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // reference model: flush tracked as "unstalled flush cycles still owed"
    logic [31:0] m_pc = RESET_PC;
    int          m_rem = 0;
    logic [31:0] m_bc = 0, m_tc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic bv,
                        input logic [31:0] bpc, input logic [31:0] imm, input logic outc);
        exp_t        e;
        logic [31:0] tgt;
        reset = rst; stall = stl; br_valid = bv; br_pc = bpc; br_imm = imm; outcome = outc;
        e.redirect = 1'b0;
        e.misalign = 1'b0;
        if (rst) begin
            m_pc = RESET_PC; m_rem = 0; m_bc = 0; m_tc = 0;
        end else if (m_rem > 0) begin
            if (!stl) begin
                m_pc  = m_pc + 32'd4;
                m_rem = m_rem - 1;
            end
        end else if (!stl) begin
            tgt = bpc + imm;
            if (bv) m_bc = m_bc + 32'd1;
            if (bv && outc === 1'b1 && (tgt % 4) == 0) begin
                m_pc = tgt; m_rem = FLUSH_CYCLES; m_tc = m_tc + 32'd1;
                e.redirect = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
                e.misalign = bv && outc === 1'b1;
            end
        end
        e.pc = m_pc; e.flush = (m_rem > 0); e.busy = (m_rem > 0);
        e.bc = m_bc; e.tc = m_tc;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // monitor: outputs are presented every cycle, so one expectation is retired per edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ($isunknown({pc, redirect, flush, busy, misalign})) begin
                n_err++;
                $display("FAIL xcheck: outputs contain X/Z pc=%h r=%b f=%b b=%b m=%b", pc, redirect, flush, busy, misalign);
            end
            chk("pc", pc, e.pc);
            chk("redirect", 32'(redirect), 32'(e.redirect));
            chk("flush", 32'(flush), 32'(e.flush));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("misalign", 32'(misalign), 32'(e.misalign));
            if (redirect && misalign) begin
                n_err++;
                $display("FAIL excl: redirect=%b misalign=%b both set", redirect, misalign);
            end
`ifdef BRANCH_STATS_EN
            chk("branch_count", branch_count, e.bc);
            chk("taken_count", taken_count, e.tc);
`endif
        end
    end

    initial begin
        logic [31:0] r, imm, bpc;
        // 1: reset then idle increment
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(4);
        // 2: taken branch at pc=0x10 -> 0x2C, flush 2 cycles
        step(1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h0000_0020, 1'b1);
        idle(3);
        // 3: not-taken branch
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0010, 1'b0);
        // 4: negative offset and wrap-around target
        step(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'hFFFF_FFF0, 1'b1);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1);
        idle(2);
        // 5: stall in first flush cycle, then misaligned target
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0040, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0040, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0006, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0010, 1'b1);
        idle(1);
        // 6: reset mid-flush with unknown outcome
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'bx);
        step(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0040, 1'bx);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r   = $urandom;
            imm = r[31] ? (32'hFFFF_F000 | (r & 32'h0000_0FFC)) : (r & 32'h0000_0FFC);
            if (r[3:0] == 4'd0) imm = imm | 32'h2;
            bpc = $urandom & 32'hFFFF_FFFC;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) < 4), bpc, imm, r[30]);
        end
        idle(1);
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Branch resolution and fetch-PC stage, directly downstream of the branch comparator. Consumes the comparator's 1-bit outcome together with the decoded branch PC and B-type offset. Owns the fetch program counter and computes the taken target. Drives a multi-cycle flush of younger instructions on every taken branch.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset.
FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch; legal range 1..7.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-high
stall  input  1  hazard hold; freezes PC and flush counter
br_valid  input  1  branch instruction present in decode this cycle
br_pc  input  32  PC of that branch instruction
br_imm  input  32  sign-extended B-type offset
outcome  input  1  comparator result, 1 = taken
pc  output  32  current fetch PC (registered)
redirect  output  1  one-cycle pulse: PC was loaded with a branch target
flush  output  1  squash younger pipeline stages
busy  output  1  FSM not in IDLE
misalign  output  1  one-cycle pulse: taken target not word-aligned

Behaviour:
- All outputs registered. Reset values: pc=RESET_PC; redirect, flush, busy, misalign = 0; FSM = IDLE; flush counter = 0. Reset wins over every other input.
- outcome is ignored while reset=1 or br_valid=0. X on outcome in those cycles must not propagate.
- Target = br_pc + br_imm, modulo 2^32. Wrap-around is silent.
- FSM states: IDLE and FLUSH.
- IDLE, stall=1: pc holds. br_valid is ignored; decode re-presents the branch later.
- IDLE, stall=0, no taken branch: pc <= pc + 4, modulo 2^32.
- IDLE, stall=0, br_valid=1, outcome=0: pc <= pc + 4. No flush.
- IDLE, stall=0, br_valid=1, outcome=1, target[1:0] != 0: treated as not-taken (pc <= pc + 4). misalign=1 for one cycle. No flush.
- IDLE, stall=0, br_valid=1, outcome=1, target aligned:
  - pc <= target; redirect=1 for one cycle.
  - flush=1, counter <= FLUSH_CYCLES-1, state -> FLUSH. Flush becomes visible the same edge pc loads.
- FLUSH, stall=0:
  - pc <= pc + 4; br_valid ignored.
  - If counter==0: flush <= 0, state -> IDLE. Otherwise counter decrements.
- FLUSH, stall=1: pc, counter and flush all hold. Flush therefore spans exactly FLUSH_CYCLES unstalled cycles.
- busy = (state == FLUSH).
- redirect and misalign are never 1 in the same cycle.
- Reset asserted mid-FLUSH: returns to IDLE next edge, flush=0, pc=RESET_PC.
- Latency: outcome sampled at edge N takes effect on pc at edge N (registered); downstream sees the new pc in cycle N+1.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds outputs branch_count[31:0] and taken_count[31:0], reset to 0.
  - branch_count increments on every non-stalled IDLE cycle with br_valid=1.
  - taken_count increments only on accepted aligned taken branches.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset 2 cycles, release, 5 idle cycles -> pc = 0x0,0x4,0x8,0xC,0x10; flush, redirect, busy all 0.
2. At pc=0x10: br_valid=1, br_pc=0xC, br_imm=0x20, outcome=1 -> next pc=0x2C, redirect one cycle, flush and busy 2 cycles, then pc=0x30,0x34.
3. br_valid=1, outcome=0 at pc=0x8 -> pc=0xC, no flush/redirect; with BRANCH_STATS_EN: branch_count=1, taken_count=0.
4. br_pc=0x8, br_imm=0xFFFF_FFF0, taken -> pc=0xFFFF_FFF8; then br_pc=0xFFFF_FFFC, br_imm=0x8, taken -> pc=0x4 (wrap).
5. Taken branch, then stall=1 for 3 cycles in first flush cycle -> pc and flush held; flush deasserts after 2 unstalled cycles. Separately: br_imm=0x6 taken -> misalign pulse, pc+4, no flush.
6. Reset asserted during FLUSH with outcome=X -> next cycle pc=RESET_PC, flush=0, busy=0; no X on any output.
